// File: rtl/multiphase_clk_gen_pkg.sv
// Shared types and pattern helpers for the multiphase rotating-pattern generator.
// Pure functions; no state, no latency.
// No flow control; helpers are evaluated combinationally by the users.
package multiphase_pkg;

  localparam int MAX_PHASES = 64;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  // Half-zero/half-one start pattern: low half of the ring is 0, high half is 1.
  function automatic logic [MAX_PHASES-1:0] init_pattern(input int n);
    logic [MAX_PHASES-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_PHASES; i++) begin
      if (i >= n / 2 && i < n) p[i] = 1'b1;
    end
    return p;
  endfunction

  // One-place ring rotation of an n-bit pattern; forward moves bit i-1 into bit i.
  function automatic logic [MAX_PHASES-1:0] rotate(input logic [MAX_PHASES-1:0] p,
                                                   input int n, input logic dir);
    logic [MAX_PHASES-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_PHASES; i++) begin
      if (i < n) begin
        if (dir == DIR_FWD) r[i] = p[(i + n - 1) % n];
        else                r[i] = p[(i + 1) % n];
      end
    end
    return r;
  endfunction

  // Start pattern rotated forward by pos places, built directly from the
  // distance of each bit to the rotation origin.
  function automatic logic [MAX_PHASES-1:0] expected_pattern(input int n, input int pos);
    logic [MAX_PHASES-1:0] r;
    int d;
    r = '0;
    for (int i = 0; i < MAX_PHASES; i++) begin
      if (i < n) begin
        d = i - pos;
        if (d < 0) d = d + n;
        r[i] = (d >= n / 2);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/multiphase_clk_gen_if.sv
// Control and phase-output bundle of the multiphase generator.
// Wires only; no latency.
// No flow control; controls are level-sampled each clk edge.
interface multiphase_clk_gen_if #(
  parameter int NUM_PHASES = 4,
  parameter int DIV_W      = 8
);
  logic                  en;
  logic [DIV_W-1:0]      div;
  logic                  dir;
  logic                  resync;
  logic [NUM_PHASES-1:0] phase;
  logic                  step;
  logic                  wrap;
  logic                  err;

  modport master (output en, div, dir, resync, input phase, step, wrap, err);
  modport slave  (input en, div, dir, resync, output phase, step, wrap, err);
endinterface

// File: rtl/multiphase_clk_gen_step_div.sv
// Programmable divider: asserts tc on the enabled edge that ends each div+1 period.
// tc is combinational from registered count; period length latched at reset/resync/tc.
// en low freezes count and latched ratio; resync restarts the period.
module phase_step_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             init_n,
  input  logic             en,
  input  logic             resync,
  input  logic [DIV_W-1:0] div,
  output logic             tc
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;

  assign tc = en && !resync && (cnt == div_q);

  // Count enabled cycles; reload ratio only at period boundaries so mid-period edits wait.
  always_ff @(posedge clk) begin
    if (!init_n || resync) begin
      cnt   <= '0;
      div_q <= div;
    end else if (en) begin
      if (cnt == div_q) begin
        cnt   <= '0;
        div_q <= div;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/multiphase_clk_gen.sv
// N-phase 50%-duty rotating ring with divide ratio, direction, resync and wrap report.
// All outputs registered; first rotation lands on enabled edge div+1 after reset release.
// en low holds state and zeroes step/wrap; MULTIPHASE_PATTERN_CHECK_EN adds a self-repairing pattern checker.
module multiphase_clk_gen
  import multiphase_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int DIV_W      = 8
) (
  input logic                clk,
  input logic                init_n,
  multiphase_clk_gen_if.slave bus
);

  localparam int POS_W = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1;
  localparam logic [POS_W-1:0]      POS_MAX = POS_W'(NUM_PHASES - 1);
  localparam logic [MAX_PHASES-1:0] INIT_W  = init_pattern(NUM_PHASES);
  localparam logic [NUM_PHASES-1:0] INIT    = INIT_W[NUM_PHASES-1:0];

  logic [NUM_PHASES-1:0] ring;
  logic [POS_W-1:0]      pos;
  logic                  step_q;
  logic                  wrap_q;
  logic                  err_q;

  logic                  tc;
  logic [NUM_PHASES-1:0] base;
  logic [NUM_PHASES-1:0] rot;
  logic [POS_W-1:0]      pos_next;
  logic [MAX_PHASES-1:0] rot_w;

  phase_step_div #(.DIV_W(DIV_W)) u_div (
    .clk    (clk),
    .init_n (init_n),
    .en     (bus.en),
    .resync (bus.resync),
    .div    (bus.div),
    .tc     (tc)
  );

`ifdef MULTIPHASE_PATTERN_CHECK_EN
  logic [MAX_PHASES-1:0] exp_w;
  logic [NUM_PHASES-1:0] expected;
  logic                  mismatch;

  // Reference ring value implied by pos; any difference is treated as corruption.
  always_comb begin
    exp_w    = expected_pattern(NUM_PHASES, int'(pos));
    expected = exp_w[NUM_PHASES-1:0];
    mismatch = (ring != expected);
  end

  // Corruption flag holds until init_n; resync repairs the ring but keeps the record.
  always_ff @(posedge clk) begin
    if (!init_n) err_q <= 1'b0;
    else if (!bus.resync && mismatch) err_q <= 1'b1;
  end

  assign base = mismatch ? expected : ring;
`else
  assign base  = ring;
  assign err_q = 1'b0;
`endif

  // Next ring value and position for a rotation in the requested direction.
  always_comb begin
    rot_w = rotate(MAX_PHASES'(base), NUM_PHASES, bus.dir);
    rot   = rot_w[NUM_PHASES-1:0];
    if (bus.dir == DIR_FWD) pos_next = (pos == POS_MAX) ? '0 : pos + 1'b1;
    else                    pos_next = (pos == '0) ? POS_MAX : pos - 1'b1;
  end

  // Ring, position and one-cycle step/wrap pulses; init_n beats resync beats rotation.
  always_ff @(posedge clk) begin
    if (!init_n || bus.resync) begin
      ring   <= INIT;
      pos    <= '0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      step_q <= tc;
      wrap_q <= tc && (pos_next == '0);
      if (tc) begin
        ring <= rot;
        pos  <= pos_next;
      end else begin
        ring <= base;
      end
    end
  end

  assign bus.phase = ring;
  assign bus.step  = step_q;
  assign bus.wrap  = wrap_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_multiphase_clk_gen.sv
// Bench for multiphase_clk_gen: vector table, directed corner sequences, randomized run vs model.
// Model tracks position arithmetically and derives the expected ring from it.
// Inputs change 1 time unit after the rising edge; outputs sampled at the same point.
module tb_multiphase_clk_gen;

`ifdef MULTIPHASE_PATTERN_CHECK_EN
  localparam int N = 8;
`else
  localparam int N = 4;
`endif
  localparam int DW = 8;

  logic clk = 1'b0;
  logic init_n;
  int   checks = 0;
  int   errors = 0;

  multiphase_clk_gen_if #(.NUM_PHASES(N), .DIV_W(DW)) bus ();

  multiphase_clk_gen #(.NUM_PHASES(N), .DIV_W(DW)) dut (
    .clk    (clk),
    .init_n (init_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Behavioural reference state
  int   m_cnt, m_divq, m_pos;
  logic m_step, m_wrap, m_err;

  function automatic logic [N-1:0] pattern_at(input int p);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (((i - p + N) % N) >= N / 2);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (!init_n) begin
      m_pos = 0; m_cnt = 0; m_divq = int'(bus.div); m_step = 0; m_wrap = 0; m_err = 0;
    end else if (bus.resync) begin
      m_pos = 0; m_cnt = 0; m_divq = int'(bus.div); m_step = 0; m_wrap = 0;
    end else if (bus.en) begin
      if (m_cnt == m_divq) begin
        m_cnt  = 0;
        m_pos  = bus.dir ? (m_pos + N - 1) % N : (m_pos + 1) % N;
        m_step = 1;
        m_wrap = (m_pos == 0);
        m_divq = int'(bus.div);
      end else begin
        m_cnt++;
        m_step = 0;
        m_wrap = 0;
      end
    end else begin
      m_step = 0;
      m_wrap = 0;
    end
  endtask

  task automatic do_cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check({tag, ".phase"}, 32'(bus.phase), 32'(pattern_at(m_pos)));
    check({tag, ".step"},  32'(bus.step),  32'(m_step));
    check({tag, ".wrap"},  32'(bus.wrap),  32'(m_wrap));
    check({tag, ".err"},   32'(bus.err),   32'(m_err));
  endtask

  task automatic drive(input logic rn, input logic e, input logic d, input logic rs, input int dv);
    init_n     = rn;
    bus.en     = e;
    bus.dir    = d;
    bus.resync = rs;
    bus.div    = DW'(dv);
  endtask

  typedef struct {
    logic       rn, e, d, rs;
    int         dv;
    logic [3:0] ph;
    logic       st, wr;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int first_step, second_step, k;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
    m_cnt = 0; m_divq = 0; m_pos = 0; m_step = 0; m_wrap = 0; m_err = 0;
    do_cycle("reset");
    check("reset.init_phase", 32'(bus.phase), 32'(pattern_at(0)));

`ifndef MULTIPHASE_PATTERN_CHECK_EN
    // div=0 forward, then div=2 reverse
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 4'b1100, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 4'b1001, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 4'b0011, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 4'b0110, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 4'b1100, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 4'b1100, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2, 4'b1100, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2, 4'b1100, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2, 4'b1100, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2, 4'b0110, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 2, 4'b0110, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 2, 4'b0110, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 2, 4'b0011, 1'b1, 1'b0};
    for (int v = 0; v < 13; v++) begin
      drive(vecs[v].rn, vecs[v].e, vecs[v].d, vecs[v].rs, vecs[v].dv);
      @(posedge clk);
      model_step();
      #1;
      check($sformatf("vec%0d.phase", v), 32'(bus.phase), 32'(vecs[v].ph));
      check($sformatf("vec%0d.step", v),  32'(bus.step),  32'(vecs[v].st));
      check($sformatf("vec%0d.wrap", v),  32'(bus.wrap),  32'(vecs[v].wr));
    end
`endif

    // div 2 -> 5 mid-period: steps after edge 3 and edge 9
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2);
    do_cycle("divchg.rst");
    init_n = 1'b1;
    first_step = -1; second_step = -1;
    for (k = 1; k <= 10; k++) begin
      if (k == 2) bus.div = DW'(5);
      do_cycle("divchg");
      if (bus.step && first_step < 0) first_step = k;
      else if (bus.step && second_step < 0) second_step = k;
    end
    check("divchg.first", 32'(first_step), 32'd3);
    check("divchg.second", 32'(second_step), 32'd9);

    // en low for 10 cycles mid-period, resume with remaining count
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3);
    do_cycle("freeze.rst");
    init_n = 1'b1;
    do_cycle("freeze.pre");
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      do_cycle("freeze.hold");
      check("freeze.phase_held", 32'(bus.phase), 32'(pattern_at(0)));
    end
    bus.en = 1'b1;
    first_step = -1;
    for (k = 1; k <= 4; k++) begin
      do_cycle("freeze.resume");
      if (bus.step && first_step < 0) first_step = k;
    end
    check("freeze.resume_step", 32'(first_step), 32'd3);

    // resync on the terminal-count edge wins over rotation
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1);
    do_cycle("resync.rst");
    init_n = 1'b1;
    do_cycle("resync.pre");
    bus.resync = 1'b1;
    do_cycle("resync.tc");
    check("resync.phase", 32'(bus.phase), 32'(pattern_at(0)));
    check("resync.step", 32'(bus.step), 32'd0);
    check("resync.wrap", 32'(bus.wrap), 32'd0);
    bus.resync = 1'b0;

    // init_n mid-operation
    bus.div = '0;
    for (int i = 0; i < 3; i++) do_cycle("midrst.run");
    init_n = 1'b0;
    do_cycle("midrst.rst");
    check("midrst.phase", 32'(bus.phase), 32'(pattern_at(0)));
    check("midrst.step", 32'(bus.step), 32'd0);
    init_n = 1'b1;

`ifdef MULTIPHASE_PATTERN_CHECK_EN
    begin
      logic [N-1:0] bad;
      bus.div = DW'(1);
      for (int i = 0; i < 3; i++) do_cycle("chk.run");
      bad = bus.phase ^ N'(1);
      force dut.ring = bad;
      #2;
      release dut.ring;
      @(posedge clk);
      model_step();
      m_err = 1'b1;
      #1;
      check("chk.err", 32'(bus.err), 32'd1);
      check("chk.phase", 32'(bus.phase), 32'(pattern_at(m_pos)));
      check("chk.step", 32'(bus.step), 32'(m_step));
      for (int i = 0; i < 6; i++) do_cycle("chk.after");
    end
`endif

    // randomized run against the model
    for (int i = 0; i < 1500; i++) begin
      bus.en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) bus.dir = ~bus.dir;
      if ($urandom_range(0, 15) == 0) bus.div = DW'($urandom_range(0, 3));
      bus.resync = ($urandom_range(0, 49) == 0);
      init_n = ($urandom_range(0, 99) != 0);
      do_cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiphase_clk_gen.md
# multiphase_clk_gen

Parametrised N-phase rotating-pattern generator: a ring of NUM_PHASES registers preloaded with a half-zero/half-one pattern, rotated once per programmable number of clock cycles. Produces NUM_PHASES equally spaced 50%-duty phase signals (quadrature for N=4) for the sensor and serial-link sampling logic. Adds divide ratio, enable, direction, resync and wrap reporting.

## Interface
- NUM_PHASES, 4: ring length; even, >= 2
- DIV_W, 8: width of divide-ratio input
- clk  in  1  sole clock; all state updates on rising edge
- init_n  in  1  synchronous, active-low reset, sampled on rising clk
- en  in  1  rotation enable; low freezes all state
- div  in  DIV_W  rotate every div+1 enabled cycles
- dir  in  1  0 = forward rotation, 1 = reverse
- resync  in  1  synchronous reload of initial pattern
- phase  out  NUM_PHASES  phase outputs, bit i = phase i*360/N degrees
- step  out  1  one-cycle pulse: phase updated on the preceding edge
- wrap  out  1  one-cycle pulse: pattern returned to initial value
- err  out  1  sticky pattern-corruption flag (see Configuration)

## Operation
- Initial pattern INIT: phase[i]=0 for i < N/2, 1 for i >= N/2 (N=4: phase[3:0]=4'b1100).
- Reset (init_n low at edge): phase=INIT, cnt=0, pos=0, div_q=div, step=0, wrap=0, err=0.
- Divider: cnt counts enabled cycles 0..div_q. On enabled edge with cnt==div_q: cnt<=0, rotate, step<=1, div_q<=div. Otherwise cnt<=cnt+1 (when en), step<=0.
- div is sampled only at reset, resync, and terminal count; mid-period changes take effect next period. div=0 rotates every enabled cycle.
- Forward: phase[i]<=phase[i-1], phase[0]<=phase[N-1]; pos<=pos+1 mod N. Reverse: phase[i]<=phase[i+1], phase[N-1]<=phase[0]; pos<=pos-1 mod N.
- wrap<=1 on a rotation whose new pos is 0; dir change is legal at any cycle and acts on the next rotation.
- en low: cnt, pos, phase, div_q hold; step and wrap forced 0 next cycle.
- resync high (en irrelevant): phase=INIT, cnt=0, pos=0, div_q=div, step=0, wrap=0; err unchanged.
- Priority: init_n > resync > rotation.

## Timing
- All outputs registered; no combinational input-to-output path.
- From reset release with en held high: first phase change on enabled edge div+1; step high for the cycle following it.
- Phase period = N*(div+1) enabled cycles; each phase high (N/2)*(div+1) cycles.
- wrap coincides with step, once per N rotations.

## Configuration
- MULTIPHASE_PATTERN_CHECK_EN defined: each cycle compares phase against INIT rotated by pos; mismatch sets err (sticky until init_n) and reloads phase from the expected pattern on the next edge, without disturbing cnt/pos.
- Not defined: no checker logic; err tied 0.

## Structure
- multiphase_pkg: init_pattern(N) function, rotate function (pattern, dir), DIR_FWD/DIR_REV constants.
- One sub-module: phase_step_div (cnt, div_q, terminal-count strobe, en/resync handling); ring, pos and checker live in the top.

## Test plan
- N=4, div=0, dir=0, en=1 after reset: phase 1100 -> 1001 -> 0011 -> 0110 -> 1100 on consecutive edges; step high every cycle; wrap on the fourth rotation.
- N=4, div=2, dir=1: phase 1100 -> 0110 after 3 edges, -> 0011 after 6; step pulses every 3rd cycle.
- Change div 2->5 mid-period: current period completes at 3 cycles, next takes 6.
- en low 10 cycles mid-period: phase/cnt frozen, step=0; resumes with remaining count.
- resync asserted same edge as terminal count: phase=INIT, no step, no wrap; init_n low mid-operation: all outputs reset values next cycle.
- With MULTIPHASE_PATTERN_CHECK_EN, N=8: force phase bit flip -> err=1 next cycle, phase restored to expected rotation, rotation cadence unchanged.
